uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

UART receiver that recovers 8N1 frames from the serial `rx` line using the shared 16x oversampling `br_tick` from the baud-rate generator. It synchronises the asynchronous line, validates the start bit at mid-bit, majority-votes each data and stop bit, and delivers the LSB-first byte with a one-cycle `rx_done` strobe. It sits beside the UART transmitter in the UART top level and shares its `br_tick`. It also serves as the loopback checker for transmitter output.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: `br_tick` pulses per bit period. Must be at least 8.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: reset, asynchronous, active-high; clock clk.
- `br_tick` input, 1 bit: one-`clk`-wide pulse, `OVERSAMPLE` pulses per bit period.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, `DATA_BITS` bits: last correctly framed byte. Holds its value until the next good frame.
- `rx_done` output, 1 bit: one-cycle pulse when a good frame completes.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
- `rx_busy` output, 1 bit: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser to produce `rx_s`. Both flops reset to 1.
- Counters:
  - `tick_cnt` is $clog2(OVERSAMPLE) bits and advances only on `br_tick`.
  - `bit_cnt` is $clog2(DATA_BITS) bits.
  - Both are cleared on every state entry.
- IDLE:
  - When `rx_s`==0, go to START.
  - Clear `tick_cnt`.
- START, on each `br_tick`:
  - At `tick_cnt`==OVERSAMPLE/2-1, if `rx_s`==0, go to DATA with `tick_cnt`=0. This aligns later sampling to mid-bit.
  - If `rx_s`==1 at that point, treat it as a glitch: return to IDLE with no output.
- Majority vote (DATA and STOP):
  - Capture `rx_s` on the `br_tick`s where `tick_cnt` = OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1.
  - The bit value is the majority of the three samples, decided on the OVERSAMPLE-1 tick.
- DATA:
  - On each decided bit, set `shift` = {bit, `shift`[DATA_BITS-1:1]}.
  - If `bit_cnt`==DATA_BITS-1, go to STOP; otherwise increment `bit_cnt`.
- STOP, on the decided stop bit:
  - If 1: load `rx_data` from `shift`, pulse `rx_done`, go to IDLE.
  - If 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This stops a held-low break from re-triggering frames.
- Reset values:
  - state IDLE.
  - `rx_data` = 0.
  - `rx_done`, `frame_err`, `rx_busy` = 0.
  - `shift` and both counters = 0.
- Reset mid-frame aborts immediately. No strobe is issued for the partial frame.

## Timing
- All outputs are registered.
- `rx` to `rx_s`: 2 `clk` latency.
- `rx_done` or `frame_err` goes high in the `clk` cycle after the edge on which the stop-bit decision `br_tick` is sampled, and lasts exactly one cycle.
- `rx_data` is valid in the same cycle `rx_done` rises.
- Because the stop bit is decided mid-bit, the receiver is back in IDLE before the stop bit ends. A back-to-back start bit from the next frame is caught with no lost frame.
- `br_tick` is ignored in IDLE and WAIT_HIGH.
- Bit period is OVERSAMPLE×(`br_tick` period). With the current generator (tick every 10 `clk`), one bit is 160 `clk` and one frame is 1600 `clk`.
- `rx_done` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `uart_pkg` holds:
  - Receiver state encodings: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Default `DATA_BITS`=8 and `OVERSAMPLE`=16 constants, shared with the transmitter.
- Sub-module `uart_rx_sync` is the 2-flop synchroniser with reset value 1, reusable for other async inputs.
- The rest is a single registered-state plus combinational next-state FSM. Every `*_next` defaults to its current register value to avoid latches.

## Test plan
Tick every 10 `clk`, 160 `clk` per bit, for all scenarios.
1. Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> exactly one `rx_done` pulse, `rx_data`=0xA5, `frame_err` stays 0, `rx_busy` high for the whole frame.
2. `rx` low for 3 ticks (30 `clk`), then high -> return to IDLE, no `rx_done`, no `frame_err`, `rx_data` unchanged.
3. Back-to-back 0x55 then 0xAA with no idle gap -> two `rx_done` pulses, `rx_data` 0x55 then 0xAA.
4. Frame 0x3C with `rx` inverted for one `br_tick` period at tick 14 of bit 2 -> majority vote holds, `rx_data`=0x3C.
5. `rx` held low for 20 bit times -> one `frame_err`, no `rx_done`, `rx_data` unchanged. Then `rx` released high and 0x81 sent -> `rx_done` with `rx_data`=0x81.
6. `reset` asserted during bit 4 of 0xFF, then a fresh 0x12 frame -> outputs return to 0 immediately, no strobe for the aborted frame, then `rx_data`=0x12 with one `rx_done`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, default frame geometry
// and the three-sample majority vote used for bit recovery.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rxState_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high; both
// stages reset to 1 so a reset never looks like a falling edge downstream.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] stages_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages_q <= 2'b11;
        end else begin
            stages_q <= {stages_q[0], async_i};
        end
    end

    assign sync_o = stages_q[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by a shared oversampling tick: mid-bit start
// validation, three-sample majority vote per bit, registered strobes.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE - 3);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE - 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rxS;
    rxState_e             state_q, state_d;
    logic [TICK_W-1:0]    tickCnt_q, tickCnt_d;
    logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samples_q, samples_d;
    logic [DATA_BITS-1:0] rxData_q, rxData_d;
    logic                 rxDone_q, rxDone_d;
    logic                 frameErr_q, frameErr_d;
    logic                 busy_q, busy_d;
    logic                 bitDecided;
    logic                 voteBit;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (rx),
        .sync_o  (rxS)
    );

    assign bitDecided = br_tick && (tickCnt_q == TICK_LAST);
    assign voteBit    = majority3(samples_q[0], samples_q[1], rxS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            samples_q  <= '0;
            rxData_q   <= '0;
            rxDone_q   <= 1'b0;
            frameErr_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            samples_q  <= samples_d;
            rxData_q   <= rxData_d;
            rxDone_q   <= rxDone_d;
            frameErr_q <= frameErr_d;
            busy_q     <= busy_d;
        end
    end

    // Counters are zeroed on every transition so each state starts its own count.
    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        samples_d = samples_q;
        rxData_d  = rxData_q;
        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
                if (!rxS) begin
                    state_d = START;
                end
            end
            START: begin
                if (br_tick) begin
                    if (tickCnt_q == TICK_MID) begin
                        tickCnt_d = '0;
                        bitCnt_d  = '0;
                        state_d   = rxS ? IDLE : DATA;
                    end else begin
                        tickCnt_d = tickCnt_q + 1'b1;
                    end
                end
            end
            DATA, STOP: begin
                if (br_tick) begin
                    tickCnt_d = tickCnt_q + 1'b1;
                    if (tickCnt_q == TICK_S0) begin
                        samples_d[0] = rxS;
                    end
                    if (tickCnt_q == TICK_S1) begin
                        samples_d[1] = rxS;
                    end
                    if (bitDecided) begin
                        tickCnt_d = '0;
                        if (state_q == DATA) begin
                            shift_d = {voteBit, shift_q[DATA_BITS-1:1]};
                            if (bitCnt_q == BIT_LAST) begin
                                bitCnt_d = '0;
                                state_d  = STOP;
                            end else begin
                                bitCnt_d = bitCnt_q + 1'b1;
                            end
                        end else begin
                            bitCnt_d = '0;
                            if (voteBit) begin
                                rxData_d = shift_q;
                                state_d  = IDLE;
                            end else begin
                                state_d  = WAIT_HIGH;
                            end
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
                if (rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rxDone_d   = 1'b0;
        frameErr_d = 1'b0;
        busy_d     = (state_d != IDLE);
        if ((state_q == STOP) && bitDecided) begin
            rxDone_d   = voteBit;
            frameErr_d = !voteBit;
        end
    end

    assign rx_data   = rxData_q;
    assign rx_done   = rxDone_q;
    assign frame_err = frameErr_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: tick every 10 clk, 160 clk per bit,
// frames driven on the negative edge, strobes counted by a posedge monitor.
module tb_uart_rx_oversampled;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       br_tick = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int assertCount  = 0;
    int failCount    = 0;
    int doneCount    = 0;
    int errCount     = 0;
    int overlapCount = 0;

    uart_rx_oversampled #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .br_tick   (br_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin : tickGen
        forever begin
            repeat (9) @(negedge clk);
            br_tick = 1'b1;
            @(negedge clk);
            br_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rx_done) doneCount <= doneCount + 1;
        if (frame_err) errCount <= errCount + 1;
        if (rx_done && frame_err) overlapCount <= overlapCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Leaves the bench on the negedge just after a br_tick posedge, so every
    // frame starts with the same tick phase.
    task automatic alignToTick();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            if (br_tick) found = 1'b1;
        end
        @(negedge clk);
        checkOutput("tickAlign", {31'd0, found}, 32'd1);
    endtask

    // Drives one frame for stopAt clk cycles; with this phase the stop-bit
    // decision tick is the posedge ending cycle 1520 of the frame.
    task automatic applyStimulus(input logic [7:0] data, input bit doAlign, input bit glitch,
                                 input int stopAt, output int busyLow,
                                 output logic doneEarly, output logic doneOnTime,
                                 output logic busyAfter);
        int   bitIdx;
        logic bitVal;
        busyLow    = 0;
        doneEarly  = 1'b0;
        doneOnTime = 1'b0;
        busyAfter  = 1'b1;
        if (doAlign) alignToTick();
        for (int n = 0; n < stopAt; n++) begin
            if (n >= 4 && n <= 1519 && !rx_busy) busyLow++;
            if (n == 1519) doneEarly = rx_done;
            if (n == 1520) doneOnTime = rx_done;
            if (n == 1525) busyAfter = rx_busy;
            bitIdx = n / 160;
            if (bitIdx == 0) bitVal = 1'b0;
            else if (bitIdx <= 8) bitVal = data[bitIdx-1];
            else bitVal = 1'b1;
            if (glitch && n >= 545 && n < 555) bitVal = ~bitVal;
            rx = bitVal;
            @(negedge clk);
        end
    endtask

    initial begin : stimulus
        int   busyLow;
        logic doneEarly, doneOnTime, busyAfter;
        int   doneBase, errBase;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetData", rx_data, 32'h00);
        checkOutput("resetDone", rx_done, 32'd0);
        checkOutput("resetErr", frame_err, 32'd0);
        checkOutput("resetBusy", rx_busy, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Clean 0xA5 frame with exact strobe timing.
        doneBase = doneCount;
        errBase  = errCount;
        applyStimulus(8'hA5, 1'b1, 1'b0, 1600, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("a5DoneCount", doneCount - doneBase, 32'd1);
        checkOutput("a5Data", rx_data, 32'hA5);
        checkOutput("a5ErrCount", errCount - errBase, 32'd0);
        checkOutput("a5BusyLow", busyLow, 32'd0);
        checkOutput("a5DoneEarly", doneEarly, 32'd0);
        checkOutput("a5DoneOnTime", doneOnTime, 32'd1);
        checkOutput("a5BusyAfter", busyAfter, 32'd0);

        // Short low glitch must be rejected at the mid-start check.
        doneBase = doneCount;
        errBase  = errCount;
        alignToTick();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("glitchBusy", rx_busy, 32'd1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("glitchIdle", rx_busy, 32'd0);
        checkOutput("glitchDone", doneCount - doneBase, 32'd0);
        checkOutput("glitchErr", errCount - errBase, 32'd0);
        checkOutput("glitchData", rx_data, 32'hA5);

        // Back-to-back frames with no idle gap.
        doneBase = doneCount;
        applyStimulus(8'h55, 1'b1, 1'b0, 1600, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("b2bFirstData", rx_data, 32'h55);
        applyStimulus(8'hAA, 1'b0, 1'b0, 1600, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("b2bSecondData", rx_data, 32'hAA);
        checkOutput("b2bDoneCount", doneCount - doneBase, 32'd2);
        checkOutput("b2bSecondBusyLow", busyLow, 32'd0);

        // One corrupted sample in bit 2 is outvoted.
        doneBase = doneCount;
        errBase  = errCount;
        applyStimulus(8'h3C, 1'b1, 1'b1, 1600, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("voteData", rx_data, 32'h3C);
        checkOutput("voteDone", doneCount - doneBase, 32'd1);
        checkOutput("voteErr", errCount - errBase, 32'd0);

        // Break: line held low for 20 bit times.
        doneBase = doneCount;
        errBase  = errCount;
        alignToTick();
        rx = 1'b0;
        repeat (3200) @(negedge clk);
        checkOutput("breakErr", errCount - errBase, 32'd1);
        checkOutput("breakDone", doneCount - doneBase, 32'd0);
        checkOutput("breakData", rx_data, 32'h3C);
        checkOutput("breakWaitBusy", rx_busy, 32'd1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("breakReleased", rx_busy, 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0, 1600, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("afterBreakData", rx_data, 32'h81);
        checkOutput("afterBreakDone", doneCount - doneBase, 32'd1);

        // Reset in the middle of bit 4 of 0xFF, then a fresh frame.
        doneBase = doneCount;
        errBase  = errCount;
        applyStimulus(8'hFF, 1'b1, 1'b0, 880, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("preResetBusy", rx_busy, 32'd1);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        checkOutput("abortData", rx_data, 32'h00);
        checkOutput("abortBusy", rx_busy, 32'd0);
        checkOutput("abortDoneLevel", rx_done, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        checkOutput("abortNoDone", doneCount - doneBase, 32'd0);
        checkOutput("abortNoErr", errCount - errBase, 32'd0);
        applyStimulus(8'h12, 1'b1, 1'b0, 1600, busyLow, doneEarly, doneOnTime, busyAfter);
        checkOutput("freshData", rx_data, 32'h12);
        checkOutput("freshDone", doneCount - doneBase, 32'd1);
        checkOutput("freshDoneOnTime", doneOnTime, 32'd1);

        checkOutput("strobeOverlap", overlapCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
